// File: rtl/adau_pkg.sv
// Shared definitions for the ADAU1761 configuration sequencer and its table ROM.
// Not clocked: types, constants and entry-builder helpers only.
// No flow control of its own.
package adau_pkg;

  localparam int PKG_MAX_BYTES = 8;
  localparam int NB_W          = $clog2(PKG_MAX_BYTES);
  localparam int DATA_W        = PKG_MAX_BYTES * 8;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_DELAY = 2'd1,
    OP_END   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  // One table entry; data is MSB-aligned, except DELAY which keeps its tick count in data[15:0].
  typedef struct packed {
    op_e               op;
    logic [NB_W-1:0]   nbytes;
    logic [15:0]       addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_DONE, S_GAP, S_DELAY, S_DONE, S_ERROR
  } state_e;

  // Codec register addresses
  localparam logic [15:0] ADDR_CLKCTRL  = 16'h4000;
  localparam logic [15:0] ADDR_PLLCTRL  = 16'h4002;
  localparam logic [15:0] ADDR_SERPORT0 = 16'h4015;
  localparam logic [15:0] ADDR_SERPORT1 = 16'h4016;
  localparam logic [15:0] ADDR_ADCCTRL  = 16'h4019;
  localparam logic [15:0] ADDR_PLBPWR   = 16'h4029;
  localparam logic [15:0] ADDR_DACCTRL0 = 16'h402A;
  localparam logic [15:0] ADDR_CLKEN0   = 16'h40F9;
  localparam logic [15:0] ADDR_CLKEN1   = 16'h40FA;

  function automatic logic [DATA_W-1:0] msb_byte(input logic [7:0] b);
    return {b, {(DATA_W-8){1'b0}}};
  endfunction

  function automatic entry_t ent_wr(input logic [15:0] addr, input logic [NB_W-1:0] nb,
                                    input logic [DATA_W-1:0] data);
    entry_t e;
    e.op     = OP_WRITE;
    e.nbytes = nb;
    e.addr   = addr;
    e.data   = data;
    return e;
  endfunction

  function automatic entry_t ent_delay(input logic [15:0] ticks);
    entry_t e;
    e.op     = OP_DELAY;
    e.nbytes = '0;
    e.addr   = '0;
    e.data   = {{(DATA_W-16){1'b0}}, ticks};
    return e;
  endfunction

  function automatic entry_t ent_end();
    entry_t e;
    e.op     = OP_END;
    e.nbytes = '0;
    e.addr   = '0;
    e.data   = '0;
    return e;
  endfunction

endpackage

// File: rtl/adau_cfg_sequencer_if.sv
// SPI write-engine request bus: level start, engine busy, and the write payload.
// Combinational bundle, no latency.
// Engine acknowledges start by raising busy; payload must hold while start is high.
interface adau_cfg_sequencer_if #(
  parameter int MAX_BYTES = 8
);
  logic                         spi_start;
  logic                         spi_busy;
  logic [$clog2(MAX_BYTES)-1:0] spi_nbytes;
  logic [15:0]                  spi_address;
  logic [MAX_BYTES*8-1:0]       spi_write_data;

  modport master (output spi_start, spi_nbytes, spi_address, spi_write_data, input spi_busy);
  modport slave  (input spi_start, spi_nbytes, spi_address, spi_write_data, output spi_busy);
endinterface

// File: rtl/adau_cfg_rom.sv
// Constant configuration table; TABLE_SEL 0 is the codec bring-up, 1 and 2 are short bring-up tables.
// One-cycle registered read: entry reflects addr sampled on the previous clk edge.
// No backpressure; reads every cycle.
module adau_cfg_rom
  import adau_pkg::*;
#(
  parameter int ROM_DEPTH = 32,
  parameter int TABLE_SEL = 0,
  localparam int AW = $clog2(ROM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  output entry_t        entry
);

  function automatic entry_t lookup(input int idx);
    entry_t e;
    e = ent_end();
    if (TABLE_SEL == 1) begin
      case (idx)
        0:       e = ent_wr(ADDR_SERPORT0, 3'd1, msb_byte(8'h01));
        1:       e = ent_delay(16'd2);
        default: e = ent_end();
      endcase
    end else if (TABLE_SEL == 2) begin
      // Every slot is a write: the run ends only by reaching the last entry.
      e = ent_wr(ADDR_SERPORT0 + 16'(idx), 3'd1, msb_byte(8'(idx + 1)));
    end else begin
      case (idx)
        0, 1, 2: e = ent_wr(ADDR_CLKCTRL, 3'd1, msb_byte(8'h00)); // SPI-mode entry
        3:       e = ent_wr(ADDR_PLLCTRL, 3'd6, {48'h007D_000C_2101, 16'h0000});
        4:       e = ent_delay(16'd2);                             // PLL lock
        5:       e = ent_wr(ADDR_CLKCTRL,  3'd1, msb_byte(8'h01));
        6:       e = ent_wr(ADDR_SERPORT0, 3'd1, msb_byte(8'h01));
        7:       e = ent_wr(ADDR_SERPORT1, 3'd1, msb_byte(8'h00));
        8:       e = ent_wr(ADDR_ADCCTRL,  3'd1, msb_byte(8'h13));
        9:       e = ent_wr(ADDR_DACCTRL0, 3'd1, msb_byte(8'h03));
        10:      e = ent_wr(ADDR_PLBPWR,   3'd1, msb_byte(8'h03));
        11:      e = ent_wr(ADDR_CLKEN0,   3'd1, msb_byte(8'h7F));
        12:      e = ent_wr(ADDR_CLKEN1,   3'd1, msb_byte(8'h03));
        default: e = ent_end();
      endcase
    end
    return e;
  endfunction

  entry_t entry_d, entry_q;

  // Table lookup for the presented index
  always_comb entry_d = lookup(int'(addr));

  // Registered read port
  always_ff @(posedge clk) begin
    if (reset) entry_q <= '0;
    else       entry_q <= entry_d;
  end

  assign entry = entry_q;

endmodule

// File: rtl/adau_cfg_sequencer.sv
// Walks the config table, issuing one SPI write per WRITE entry and waiting out DELAY entries.
// go -> FETCH next cycle -> DECODE -> spi_start two cycles after FETCH; done/error held until next go.
// Holds spi_start until the engine raises busy (bounded by BUSY_TIMEOUT), then waits for busy low plus a gap.
module adau_cfg_sequencer
  import adau_pkg::*;
#(
  parameter int ROM_DEPTH    = 32,
  parameter int MAX_BYTES    = 8,
  parameter int GAP_CYCLES   = 200,
  parameter int TICK_CYCLES  = 100000,
  parameter int BUSY_TIMEOUT = 64,
  parameter int TABLE_SEL    = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         go,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [$clog2(ROM_DEPTH)-1:0] step,
  adau_cfg_sequencer_if.master         spi
);

  localparam int SW  = $clog2(ROM_DEPTH);
  localparam int NBW = $clog2(MAX_BYTES);
  localparam int TW  = $clog2(TICK_CYCLES);
  localparam int GW  = $clog2(GAP_CYCLES);
  localparam int OW  = $clog2(BUSY_TIMEOUT);

  state_e                 state_q,    state_d;
  logic [SW-1:0]          step_q,     step_d;
  logic [NBW-1:0]         nbytes_q,   nbytes_d;
  logic [15:0]            addr_q,     addr_d;
  logic [MAX_BYTES*8-1:0] wdata_q,    wdata_d;
  logic [OW-1:0]          to_cnt_q,   to_cnt_d;
  logic [GW-1:0]          gap_cnt_q,  gap_cnt_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [15:0]            dly_cnt_q,  dly_cnt_d;
  logic                   adv;
  entry_t                 rom_ent;

  adau_cfg_rom #(.ROM_DEPTH(ROM_DEPTH), .TABLE_SEL(TABLE_SEL)) u_rom (
    .clk   (clk),
    .reset (reset),
    .addr  (step_q),
    .entry (rom_ent)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      nbytes_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      tick_cnt_q <= '0;
      dly_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      nbytes_q   <= nbytes_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
    end
  end

  // Next state, counters and payload latch; adv applies the shared step-advance / last-entry rule
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    nbytes_d   = nbytes_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    to_cnt_d   = to_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tick_cnt_d = tick_cnt_q;
    dly_cnt_d  = dly_cnt_q;
    adv        = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (go) begin
          state_d = S_FETCH;
          step_d  = '0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (rom_ent.op)
          OP_WRITE: begin
            nbytes_d = NBW'(rom_ent.nbytes);
            addr_d   = rom_ent.addr;
            wdata_d  = rom_ent.data[DATA_W-1 -: MAX_BYTES*8];
            to_cnt_d = '0;
            state_d  = S_ISSUE;
          end
          OP_DELAY: begin
            dly_cnt_d  = rom_ent.data[15:0];
            tick_cnt_d = '0;
            // A zero-length delay falls straight through to the next entry.
            if (rom_ent.data[15:0] == 16'd0) adv = 1'b1;
            else                             state_d = S_DELAY;
          end
          default: state_d = S_DONE;
        endcase
      end
      S_ISSUE: begin
        if (spi.spi_busy)                                state_d  = S_WAIT_DONE;
        else if (to_cnt_q == OW'(BUSY_TIMEOUT - 1))      state_d  = S_ERROR;
        else                                             to_cnt_d = to_cnt_q + 1'b1;
      end
      S_WAIT_DONE: begin
        if (!spi.spi_busy) begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) adv = 1'b1;
        else                                  gap_cnt_d = gap_cnt_q + 1'b1;
      end
      S_DELAY: begin
        if (tick_cnt_q == TW'(TICK_CYCLES - 1)) begin
          tick_cnt_d = '0;
          if (dly_cnt_q == 16'd1) adv = 1'b1;
          else                    dly_cnt_d = dly_cnt_q - 16'd1;
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (adv) begin
      if (step_q == SW'(ROM_DEPTH - 1)) begin
        state_d = S_DONE;
      end else begin
        step_d  = step_q + 1'b1;
        state_d = S_FETCH;
      end
    end
  end

  // Status and start decoded from state; payload comes straight from the latch
  always_comb begin
    busy          = 1'b1;
    done          = 1'b0;
    error         = 1'b0;
    spi.spi_start = 1'b0;
    case (state_q)
      S_IDLE:  busy = 1'b0;
      S_DONE:  begin busy = 1'b0; done  = 1'b1; end
      S_ERROR: begin busy = 1'b0; error = 1'b1; end
      S_ISSUE: spi.spi_start = 1'b1;
      default: ;
    endcase
  end

  assign step               = step_q;
  assign spi.spi_nbytes     = nbytes_q;
  assign spi.spi_address    = addr_q;
  assign spi.spi_write_data = wdata_q;

endmodule

// File: tb/tb_adau_cfg_sequencer.sv
// Directed bench: three sequencer instances (codec table, write+delay table, no-END table),
// each with a model SPI engine (busy 3 cycles after a start edge, 40 cycles long).
// Checks are immediate assertions; timing expectations are derived from the cycle timeline.
module tb_adau_cfg_sequencer;

  localparam int GAP  = 20;
  localparam int TICK = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- instance A: codec table ----------------
  logic       a_go = 1'b0, a_busy, a_done, a_error, a_en = 1'b1, a_prev;
  logic [4:0] a_step;
  int         a_dly, a_bcnt;
  logic [15:0] a_log_addr[$];
  logic [2:0]  a_log_nb[$];
  logic [63:0] a_log_data[$];
  adau_cfg_sequencer_if #(.MAX_BYTES(8)) a_if ();
  adau_cfg_sequencer #(.ROM_DEPTH(32), .MAX_BYTES(8), .GAP_CYCLES(GAP), .TICK_CYCLES(TICK),
                       .BUSY_TIMEOUT(64), .TABLE_SEL(0)) u_a (
    .clk(clk), .reset(reset), .go(a_go), .busy(a_busy), .done(a_done), .error(a_error),
    .step(a_step), .spi(a_if));

  always @(posedge clk) begin
    a_prev <= a_if.spi_start;
    if (reset) begin
      a_dly <= 0; a_bcnt <= 0; a_if.spi_busy <= 1'b0;
    end else begin
      if (a_if.spi_start && !a_prev) begin
        a_log_addr.push_back(a_if.spi_address);
        a_log_nb.push_back(a_if.spi_nbytes);
        a_log_data.push_back(a_if.spi_write_data);
      end
      if (a_if.spi_start && !a_prev && a_en) a_dly <= 3;
      else if (a_dly != 0)                   a_dly <= a_dly - 1;
      if (a_dly == 1) begin a_if.spi_busy <= 1'b1; a_bcnt <= 40; end
      else if (a_bcnt != 0) begin
        a_bcnt <= a_bcnt - 1;
        if (a_bcnt == 1) a_if.spi_busy <= 1'b0;
      end
    end
  end

  // ---------------- instance B: WRITE, DELAY 2, END ----------------
  logic       b_go = 1'b0, b_busy, b_done, b_error, b_prev;
  logic [1:0] b_step;
  int         b_dly, b_bcnt, b_cnt;
  adau_cfg_sequencer_if #(.MAX_BYTES(8)) b_if ();
  adau_cfg_sequencer #(.ROM_DEPTH(4), .MAX_BYTES(8), .GAP_CYCLES(GAP), .TICK_CYCLES(TICK),
                       .BUSY_TIMEOUT(64), .TABLE_SEL(1)) u_b (
    .clk(clk), .reset(reset), .go(b_go), .busy(b_busy), .done(b_done), .error(b_error),
    .step(b_step), .spi(b_if));

  always @(posedge clk) begin
    b_prev <= b_if.spi_start;
    if (reset) begin
      b_dly <= 0; b_bcnt <= 0; b_cnt <= 0; b_if.spi_busy <= 1'b0;
    end else begin
      if (b_if.spi_start && !b_prev) begin b_dly <= 3; b_cnt <= b_cnt + 1; end
      else if (b_dly != 0)           b_dly <= b_dly - 1;
      if (b_dly == 1) begin b_if.spi_busy <= 1'b1; b_bcnt <= 40; end
      else if (b_bcnt != 0) begin
        b_bcnt <= b_bcnt - 1;
        if (b_bcnt == 1) b_if.spi_busy <= 1'b0;
      end
    end
  end

  // ---------------- instance C: four WRITEs, no END ----------------
  logic       c_go = 1'b0, c_busy, c_done, c_error, c_prev;
  logic [1:0] c_step;
  int         c_dly, c_bcnt, c_cnt;
  adau_cfg_sequencer_if #(.MAX_BYTES(8)) c_if ();
  adau_cfg_sequencer #(.ROM_DEPTH(4), .MAX_BYTES(8), .GAP_CYCLES(GAP), .TICK_CYCLES(TICK),
                       .BUSY_TIMEOUT(64), .TABLE_SEL(2)) u_c (
    .clk(clk), .reset(reset), .go(c_go), .busy(c_busy), .done(c_done), .error(c_error),
    .step(c_step), .spi(c_if));

  always @(posedge clk) begin
    c_prev <= c_if.spi_start;
    if (reset) begin
      c_dly <= 0; c_bcnt <= 0; c_cnt <= 0; c_if.spi_busy <= 1'b0;
    end else begin
      if (c_if.spi_start && !c_prev) begin c_dly <= 3; c_cnt <= c_cnt + 1; end
      else if (c_dly != 0)           c_dly <= c_dly - 1;
      if (c_dly == 1) begin c_if.spi_busy <= 1'b1; c_bcnt <= 40; end
      else if (c_bcnt != 0) begin
        c_bcnt <= c_bcnt - 1;
        if (c_bcnt == 1) c_if.spi_busy <= 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n, s;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    chk("rst_busy",   a_busy, 0);
    chk("rst_done",   a_done, 0);
    chk("rst_error",  a_error, 0);
    chk("rst_step",   a_step, 0);
    chk("rst_start",  a_if.spi_start, 0);
    chk("rst_nbytes", a_if.spi_nbytes, 0);
    chk("rst_addr",   a_if.spi_address, 0);
    chk("rst_wdata",  a_if.spi_write_data, 0);

    // Codec table: go at cycle 0, FETCH 1, DECODE 2, start from 3
    a_go = 1'b1; tick(1); a_go = 1'b0;
    chk("fetch_busy",  a_busy, 1);
    chk("fetch_start", a_if.spi_start, 0);
    tick(1);
    chk("decode_start", a_if.spi_start, 0);
    tick(1);
    chk("issue_start", a_if.spi_start, 1);
    chk("issue_addr",  a_if.spi_address, 16'h4000);
    chk("issue_nb",    a_if.spi_nbytes, 1);
    chk("issue_data",  a_if.spi_write_data, 0);
    for (int i = 0; i < 50 && !a_if.spi_busy; i++) tick(1);
    chk("eng_busy_seen", a_if.spi_busy, 1);
    chk("start_held_with_busy", a_if.spi_start, 1);
    tick(1);
    chk("start_dropped", a_if.spi_start, 0);
    // go while running (WAIT_DONE) must be ignored
    a_go = 1'b1; tick(1); a_go = 1'b0;
    chk("go_ignored_step", a_step, 0);
    chk("go_ignored_busy", a_busy, 1);
    for (int i = 0; i < 100 && a_if.spi_busy; i++) tick(1);
    chk("eng_busy_fell", a_if.spi_busy, 0);
    // busy-low cycle, GAP cycles of gap, FETCH, DECODE, then start
    n = 0;
    for (int i = 0; i < 200 && !a_if.spi_start; i++) begin tick(1); n++; end
    chk("gap_to_next_start", n, GAP + 3);
    for (int i = 0; i < 4000 && !a_done; i++) tick(1);
    chk("run_done",  a_done, 1);
    chk("run_busy",  a_busy, 0);
    chk("run_error", a_error, 0);
    chk("run_step",  a_step, 13);
    chk("log_count", a_log_addr.size(), 12);
    if (a_log_addr.size() == 12) begin
      chk("log0_addr", a_log_addr[0], 16'h4000);
      chk("log1_addr", a_log_addr[1], 16'h4000);
      chk("log2_addr", a_log_addr[2], 16'h4000);
      chk("pll_addr",  a_log_addr[3], 16'h4002);
      chk("pll_nb",    a_log_nb[3], 6);
      chk("pll_data",  a_log_data[3], 64'h007D_000C_2101_0000);
      chk("log4_addr", a_log_addr[4], 16'h4000);
      chk("log4_data", a_log_data[4], 64'h0100_0000_0000_0000);
      chk("log11_addr", a_log_addr[11], 16'h40FA);
    end

    // Timeout: engine never answers; 64 ISSUE cycles then ERROR
    a_en = 1'b0;
    a_go = 1'b1; tick(1); a_go = 1'b0;
    chk("go_clears_done", a_done, 0);
    n = 0;
    for (int i = 0; i < 200 && !a_error; i++) begin tick(1); n += int'(a_if.spi_start); end
    chk("to_issue_cycles", n, 64);
    chk("to_error", a_error, 1);
    chk("to_busy",  a_busy, 0);
    chk("to_step",  a_step, 0);
    chk("to_start", a_if.spi_start, 0);
    tick(5);
    chk("to_start_later", a_if.spi_start, 0);
    chk("to_error_held",  a_error, 1);

    // Reset during the PLL write's WAIT_DONE
    a_en = 1'b1;
    a_go = 1'b1; tick(1); a_go = 1'b0;
    for (int i = 0; i < 2000 && !(a_step == 5'd3 && a_if.spi_busy); i++) tick(1);
    tick(2);
    chk("pre_rst_addr", a_if.spi_address, 16'h4002);
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("mid_rst_busy",   a_busy, 0);
    chk("mid_rst_done",   a_done, 0);
    chk("mid_rst_error",  a_error, 0);
    chk("mid_rst_step",   a_step, 0);
    chk("mid_rst_start",  a_if.spi_start, 0);
    chk("mid_rst_nbytes", a_if.spi_nbytes, 0);
    chk("mid_rst_addr",   a_if.spi_address, 0);
    chk("mid_rst_wdata",  a_if.spi_write_data, 0);
    a_go = 1'b1; tick(1); a_go = 1'b0;
    chk("restart_step", a_step, 0);
    chk("restart_busy", a_busy, 1);
    tick(2);
    chk("restart_start", a_if.spi_start, 1);
    chk("restart_addr",  a_if.spi_address, 16'h4000);

    // WRITE, DELAY 2, END with TICK=10. From the busy-low cycle:
    // GAP 20 + FETCH + DECODE + DELAY 20 + FETCH + DECODE, DONE on the 45th cycle.
    b_go = 1'b1; tick(1); b_go = 1'b0;
    for (int i = 0; i < 50 && !b_if.spi_busy; i++) tick(1);
    for (int i = 0; i < 100 && b_if.spi_busy; i++) tick(1);
    chk("b_busy_fell", b_if.spi_busy, 0);
    chk("b_addr", b_if.spi_address, 16'h4015);
    chk("b_data", b_if.spi_write_data, 64'h0100_0000_0000_0000);
    n = 0; s = 0;
    for (int i = 0; i < 200 && !b_done; i++) begin tick(1); n++; s += int'(b_if.spi_start); end
    chk("b_cycles_to_done", n, GAP + 25);
    chk("b_no_start_in_delay", s, 0);
    chk("b_step", b_step, 2);
    chk("b_busy", b_busy, 0);
    chk("b_txn_count", b_cnt, 1);

    // No END: done after the last entry's gap, no wrap
    c_go = 1'b1; tick(1); c_go = 1'b0;
    for (int i = 0; i < 2000 && !(c_cnt == 4 && c_if.spi_busy); i++) tick(1);
    for (int i = 0; i < 100 && c_if.spi_busy; i++) tick(1);
    chk("c_last_busy_fell", c_if.spi_busy, 0);
    n = 0;
    for (int i = 0; i < 200 && !c_done; i++) begin tick(1); n++; end
    chk("c_cycles_to_done", n, GAP + 1);
    chk("c_step",  c_step, 3);
    chk("c_busy",  c_busy, 0);
    chk("c_addr",  c_if.spi_address, 16'h4018);
    chk("c_data",  c_if.spi_write_data, 64'h0400_0000_0000_0000);
    tick(30);
    chk("c_no_wrap_cnt", c_cnt, 4);
    chk("c_done_held",   c_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
